// File: rtl/xilinx_tdp_bytewe_ram_if.sv
// Two-port RAM bus bundle: port A (pixel writer), port B (scan-out reader).
// Carries enables, byte write enables, addresses, data, read-valid flags and collision.
interface xilinx_tdp_bytewe_ram_if #(
  parameter int RAM_WIDTH  = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RAM_DEPTH  = 1024
);
  localparam int NB = RAM_WIDTH / BYTE_WIDTH;
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic                 ena;
  logic                 enb;
  logic [NB-1:0]        wea;
  logic [NB-1:0]        web;
  logic [AW-1:0]        addra;
  logic [AW-1:0]        addrb;
  logic [RAM_WIDTH-1:0] dina;
  logic [RAM_WIDTH-1:0] dinb;
  logic                 regcea;
  logic                 regceb;
  logic [RAM_WIDTH-1:0] douta;
  logic [RAM_WIDTH-1:0] doutb;
  logic                 douta_vld;
  logic                 doutb_vld;
  logic                 collision;

  modport master (
    output ena, enb, wea, web, addra, addrb,
    output dina, dinb, regcea, regceb,
    input  douta, doutb, douta_vld, doutb_vld,
    input  collision
  );

  modport slave (
    input  ena, enb, wea, web, addra, addrb,
    input  dina, dinb, regcea, regceb,
    output douta, doutb, douta_vld, doutb_vld,
    output collision
  );
endinterface

// File: rtl/xilinx_tdp_bytewe_ram.sv
// True dual-port byte-write BRAM, single clock, port A wins byte collisions.
// Define TDP_RAM_COLLISION_DETECT_EN to drive the registered collision pulse.
module xilinx_tdp_bytewe_ram #(
  parameter int    RAM_WIDTH  = 32,
  parameter int    BYTE_WIDTH = 8,
  parameter int    RAM_DEPTH  = 1024,
  parameter int    READ_MODE  = 0,
  parameter int    OUT_REG    = 1,
  parameter string INIT_FILE  = ""
) (
  input logic clka,
  input logic rst,
  xilinx_tdp_bytewe_ram_if.slave bus
);
  localparam int NB = RAM_WIDTH / BYTE_WIDTH;
  localparam int BW = BYTE_WIDTH;
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = RAM_DEPTH[AW:0];
  localparam int RM_WRITE_FIRST = 1;
  localparam int RM_NO_CHANGE   = 2;

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

  // Power-up contents only; reset never touches the array
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) r_mem[i] = '0;
  end

  logic                 w_en    [2];
  logic [NB-1:0]        w_we    [2];
  logic [AW-1:0]        w_addr  [2];
  logic [RAM_WIDTH-1:0] w_din   [2];
  logic                 w_regce [2];
  logic                 w_ok    [2];
  logic [NB-1:0]        w_wr    [2];
  logic [RAM_WIDTH-1:0] w_old   [2];
  logic [RAM_WIDTH-1:0] w_fin   [2];
  logic                 w_ld    [2];
  logic [RAM_WIDTH-1:0] w_dout  [2];
  logic                 w_vld   [2];
  logic                 w_same;
  logic                 w_unused_regce;

  assign w_en[0]    = bus.ena;
  assign w_en[1]    = bus.enb;
  assign w_we[0]    = bus.wea;
  assign w_we[1]    = bus.web;
  assign w_addr[0]  = bus.addra;
  assign w_addr[1]  = bus.addrb;
  assign w_din[0]   = bus.dina;
  assign w_din[1]   = bus.dinb;
  assign w_regce[0] = bus.regcea;
  assign w_regce[1] = bus.regceb;

  assign w_unused_regce = w_regce[0] ^ w_regce[1];

  assign w_same = w_en[0] && w_en[1]
               && (w_addr[0] == w_addr[1]);

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign w_ok[p]  = {1'b0, w_addr[p]} < DEPTH_W;
    assign w_wr[p]  = (w_en[p] && w_ok[p]) ? w_we[p] : '0;
    assign w_old[p] = w_ok[p] ? r_mem[w_addr[p]] : '0;
    assign w_ld[p]  = w_en[p] && !((w_we[p] != '0)
                   && (READ_MODE == RM_NO_CHANGE));
  end

  // Word each port sees after this edge's writes, A over B per byte
  always_comb begin
    w_fin[0] = w_old[0];
    w_fin[1] = w_old[1];
    for (int i = 0; i < NB; i++) begin
      if (w_wr[0][i])
        w_fin[0][i*BW +: BW] = w_din[0][i*BW +: BW];
      else if (w_same && w_wr[1][i])
        w_fin[0][i*BW +: BW] = w_din[1][i*BW +: BW];
      if (w_same && w_wr[0][i])
        w_fin[1][i*BW +: BW] = w_din[0][i*BW +: BW];
      else if (w_wr[1][i])
        w_fin[1][i*BW +: BW] = w_din[1][i*BW +: BW];
    end
  end

  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wr[1][i] && !(w_same && w_wr[0][i]))
        r_mem[w_addr[1]][i*BW +: BW] <= w_din[1][i*BW +: BW];
      if (w_wr[0][i])
        r_mem[w_addr[0]][i*BW +: BW] <= w_din[0][i*BW +: BW];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pipe
    logic [RAM_WIDTH-1:0] r_d1;
    logic                 r_v1;

    always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
        r_d1 <= '0;
        r_v1 <= 1'b0;
      end else begin
        r_v1 <= w_ld[p];
        if (w_ld[p])
          r_d1 <= ((w_we[p] != '0) && (READ_MODE == RM_WRITE_FIRST))
                ? w_fin[p] : w_old[p];
      end
    end

    if (OUT_REG != 0) begin : g_reg
      logic [RAM_WIDTH-1:0] r_d2;
      logic                 r_v2;
      logic                 r_pend;

      // r_pend marks a stage-1 word not yet handed to stage 2
      always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
          r_d2   <= '0;
          r_v2   <= 1'b0;
          r_pend <= 1'b0;
        end else begin
          if (w_regce[p]) begin
            r_d2 <= r_d1;
            r_v2 <= r_pend;
          end else begin
            r_v2 <= 1'b0;
          end
          if (w_ld[p])         r_pend <= 1'b1;
          else if (w_regce[p]) r_pend <= 1'b0;
        end
      end

      assign w_dout[p] = r_d2;
      assign w_vld[p]  = r_v2;
    end else begin : g_noreg
      assign w_dout[p] = r_d1;
      assign w_vld[p]  = r_v1;
    end
  end

  assign bus.douta     = w_dout[0];
  assign bus.doutb     = w_dout[1];
  assign bus.douta_vld = w_vld[0];
  assign bus.doutb_vld = w_vld[1];

`ifdef TDP_RAM_COLLISION_DETECT_EN
  logic r_coll;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) r_coll <= 1'b0;
    else     r_coll <= w_same && ((w_we[0] | w_we[1]) != '0);
  end

  assign bus.collision = r_coll;
`else
  assign bus.collision = 1'b0;
`endif
endmodule

// File: tb/tb_xilinx_tdp_bytewe_ram.sv
// Bench: three RAM configs (RF/OUT_REG=1/depth 1000, WF/OUT_REG=0, NC/OUT_REG=0)
// driven by one shared directed stimulus stream.
module tb_xilinx_tdp_bytewe_ram;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_on = 1'b1;

  logic        ena, enb, regcea, regceb;
  logic [3:0]  wea, web;
  logic [9:0]  addra, addrb;
  logic [31:0] dina, dinb;

  int nerr = 0;
  int nchk = 0;

`ifdef TDP_RAM_COLLISION_DETECT_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif

  xilinx_tdp_bytewe_ram_if #(.RAM_DEPTH(1000)) b0 ();
  xilinx_tdp_bytewe_ram_if #(.RAM_DEPTH(1024)) b1 ();
  xilinx_tdp_bytewe_ram_if #(.RAM_DEPTH(1024)) b2 ();

  assign b0.ena = ena;   assign b0.enb = enb;
  assign b0.wea = wea;   assign b0.web = web;
  assign b0.addra = addra; assign b0.addrb = addrb;
  assign b0.dina = dina; assign b0.dinb = dinb;
  assign b0.regcea = regcea; assign b0.regceb = regceb;
  assign b1.ena = ena;   assign b1.enb = enb;
  assign b1.wea = wea;   assign b1.web = web;
  assign b1.addra = addra; assign b1.addrb = addrb;
  assign b1.dina = dina; assign b1.dinb = dinb;
  assign b1.regcea = regcea; assign b1.regceb = regceb;
  assign b2.ena = ena;   assign b2.enb = enb;
  assign b2.wea = wea;   assign b2.web = web;
  assign b2.addra = addra; assign b2.addrb = addrb;
  assign b2.dina = dina; assign b2.dinb = dinb;
  assign b2.regcea = regcea; assign b2.regceb = regceb;

  xilinx_tdp_bytewe_ram #(
    .RAM_DEPTH(1000), .READ_MODE(0), .OUT_REG(1)
  ) u0 (.clka(clk), .rst(rst), .bus(b0));

  xilinx_tdp_bytewe_ram #(
    .RAM_DEPTH(1024), .READ_MODE(1), .OUT_REG(0)
  ) u1 (.clka(clk), .rst(rst), .bus(b1));

  xilinx_tdp_bytewe_ram #(
    .RAM_DEPTH(1024), .READ_MODE(2), .OUT_REG(0)
  ) u2 (.clka(clk), .rst(rst), .bus(b2));

  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0;
    wea = '0;   web = '0;
  endtask

  task automatic wr_a(input logic [9:0] a, input logic [31:0] d);
    ena = 1'b1; wea = 4'hF; addra = a; dina = d;
    step();
  endtask

  initial begin
    idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    regcea = 1'b1; regceb = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;

    // preload and leave a non-zero word on douta
    wr_a(10'd5,   32'h11223344);
    wr_a(10'd3,   32'hCAFEF00D);
    wr_a(10'd999, 32'h99999999);
    wr_a(10'd7,   32'h00000000);
    wea = '0; addra = 10'd5;
    step(); step();
    idle();

    // async reset with the clock stopped
    clk_on = 1'b0;
    #4 rst = 1'b1;
    #3;
    chk("rst_d0_douta", b0.douta, 32'h0);
    chk("rst_d0_vlda",  {31'b0, b0.douta_vld}, 32'h0);
    chk("rst_d1_douta", b1.douta, 32'h0);
    chk("rst_d2_douta", b2.douta, 32'h0);
    chk("rst_coll",     {31'b0, b0.collision}, 32'h0);
    rst = 1'b0;
    #3 clk_on = 1'b1;

    // byte write 0101 on word 5
    ena = 1'b1; wea = 4'b0101; addra = 10'd5; dina = 32'hAABBCCDD;
    step();
    chk("bw_d0_lat_vld", {31'b0, b0.douta_vld}, 32'h0);
    chk("bw_d1_wf",      b1.douta, 32'h11BB33DD);
    chk("bw_d1_vld",     {31'b0, b1.douta_vld}, 32'h1);
    chk("bw_d2_nc_vld",  {31'b0, b2.douta_vld}, 32'h0);
    chk("bw_d2_nc_hold", b2.douta, 32'h0);
    wea = '0;
    step();
    chk("bw_d0_rf_old",  b0.douta, 32'h11223344);
    chk("bw_d2_read",    b2.douta, 32'h11BB33DD);
    chk("bw_d2_vld",     {31'b0, b2.douta_vld}, 32'h1);
    idle();
    step();
    chk("bw_d0_read",    b0.douta, 32'h11BB33DD);
    chk("bw_d0_vld",     {31'b0, b0.douta_vld}, 32'h1);
    chk("en0_d1_vld",    {31'b0, b1.douta_vld}, 32'h0);

    // same-port full-word write on word 3
    wr_a(10'd3, 32'h12345678);
    chk("rm_d1_wf",      b1.douta, 32'h12345678);
    chk("rm_d2_hold",    b2.douta, 32'h11BB33DD);
    chk("rm_d2_vld",     {31'b0, b2.douta_vld}, 32'h0);
    idle();
    step();
    chk("rm_d0_rf",      b0.douta, 32'hCAFEF00D);
    ena = 1'b1; addra = 10'd3;
    step();
    chk("rm_d2_mem",     b2.douta, 32'h12345678);
    idle();

    // both ports write word 7
    ena = 1'b1; wea = 4'b0011; addra = 10'd7; dina = 32'hAAAAAAAA;
    enb = 1'b1; web = 4'b1111; addrb = 10'd7; dinb = 32'hBBBBBBBB;
    step();
    chk("col_d1_a",      b1.douta, 32'hBBBBAAAA);
    chk("col_d1_b",      b1.doutb, 32'hBBBBAAAA);
    chk("col_pulse",     {31'b0, b0.collision}, {31'b0, COLL});
    wea = 4'hF; dina = 32'h55555555; web = '0;
    step();
    chk("awbr_d1_b_old", b1.doutb, 32'hBBBBAAAA);
    chk("awbr_d1_a",     b1.douta, 32'h55555555);
    chk("awbr_d0_b_lat", b0.doutb, 32'h0);
    idle();
    step();
    chk("awbr_d0_b",     b0.doutb, 32'hBBBBAAAA);
    chk("col_clear",     {31'b0, b0.collision}, 32'h0);

    // regceb stall on the pipelined config
    wr_a(10'd0, 32'h10000000);
    wr_a(10'd1, 32'h10000001);
    wr_a(10'd2, 32'h10000002);
    idle();
    enb = 1'b1; addrb = 10'd0;
    step();
    chk("st_s0_vld",     {31'b0, b0.doutb_vld}, 32'h0);
    regceb = 1'b0; addrb = 10'd1;
    step();
    chk("st_s1_hold",    b0.doutb, 32'hBBBBAAAA);
    chk("st_s1_vld",     {31'b0, b0.doutb_vld}, 32'h0);
    addrb = 10'd2;
    step();
    chk("st_s2_hold",    b0.doutb, 32'hBBBBAAAA);
    chk("st_s2_vld",     {31'b0, b0.doutb_vld}, 32'h0);
    enb = 1'b0; regceb = 1'b1;
    step();
    chk("st_s3_data",    b0.doutb, 32'h10000002);
    chk("st_s3_vld",     {31'b0, b0.doutb_vld}, 32'h1);
    step();
    chk("st_s4_nodup",   {31'b0, b0.doutb_vld}, 32'h0);

    // out-of-range address on depth 1000
    ena = 1'b1; wea = '0; addra = 10'd999;
    step();
    wea = 4'hF; addra = 10'd1023; dina = 32'hDEADBEEF;
    step();
    chk("oor_pre_999",   b0.douta, 32'h99999999);
    wea = '0;
    step();
    chk("oor_wr_rd0",    b0.douta, 32'h0);
    chk("oor_wr_vld",    {31'b0, b0.douta_vld}, 32'h1);
    addra = 10'd999;
    step();
    chk("oor_rd0",       b0.douta, 32'h0);
    chk("oor_rd_vld",    {31'b0, b0.douta_vld}, 32'h1);
    idle();
    step();
    chk("oor_999_kept",  b0.douta, 32'h99999999);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
